// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the register-file hazard scoreboard.
package scoreboard_pkg;

  localparam int unsigned MaxPending = 3;
  localparam int unsigned CntWidth   = $clog2(MaxPending + 1);
  localparam int unsigned AddrWidth  = 4;

  typedef logic [CntWidth-1:0] pend_cnt_t;

  typedef struct packed {
    logic                 valid;
    logic                 is_vector;
    logic                 uses_reg1;
    logic                 uses_reg2;
    logic                 writes_dest;
    logic [AddrWidth-1:0] reg1_addr;
    logic [AddrWidth-1:0] reg2_addr;
    logic [AddrWidth-1:0] dest_addr;
  } issue_req_t;

endpackage

// File: rtl/pending_table.sv
// Per-register outstanding-write counters for one register file, with
// writeback-bypassed effective-count read ports and a registered pending mask.
module pending_table
  import scoreboard_pkg::*;
#(
  parameter int unsigned RegNum = 16,
  parameter int unsigned AddrW  = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic [AddrW-1:0] inc_addr_i,
  input  logic             dec_i,
  input  logic [AddrW-1:0] dec_addr_i,
  input  logic [AddrW-1:0] rd1_addr_i,
  input  logic [AddrW-1:0] rd2_addr_i,
  input  logic [AddrW-1:0] rdd_addr_i,
  output pend_cnt_t        rd1_cnt_o,
  output pend_cnt_t        rd2_cnt_o,
  output pend_cnt_t        rdd_cnt_o,
  output logic [RegNum-1:0] mask_o,
  output logic             underflow_o
);

  pend_cnt_t         cnt_q [RegNum];
  pend_cnt_t         cnt_d [RegNum];
  logic [RegNum-1:0] mask_q, mask_d;
  pend_cnt_t         rd1_raw, rd2_raw, rdd_raw;

  // A same-cycle writeback is visible to readers, so it counts as already retired.
  function automatic pend_cnt_t bypass(pend_cnt_t c, logic [AddrW-1:0] a,
                                       logic dv, logic [AddrW-1:0] da);
    if (dv && (a == da) && (c != '0)) begin
      return c - pend_cnt_t'(1);
    end
    return c;
  endfunction

  // Out-of-range addresses match no entry and so read as zero (hazard-free).
  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    rdd_raw = '0;
    for (int unsigned i = 0; i < RegNum; i++) begin
      if (32'(rd1_addr_i) == i) rd1_raw = cnt_q[i];
      if (32'(rd2_addr_i) == i) rd2_raw = cnt_q[i];
      if (32'(rdd_addr_i) == i) rdd_raw = cnt_q[i];
    end
    rd1_cnt_o = bypass(rd1_raw, rd1_addr_i, dec_i, dec_addr_i);
    rd2_cnt_o = bypass(rd2_raw, rd2_addr_i, dec_i, dec_addr_i);
    rdd_cnt_o = bypass(rdd_raw, rdd_addr_i, dec_i, dec_addr_i);
  end

  always_comb begin
    underflow_o = 1'b0;
    for (int unsigned i = 0; i < RegNum; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_i && (32'(inc_addr_i) == i) && !(dec_i && (32'(dec_addr_i) == i))) begin
        cnt_d[i] = cnt_q[i] + pend_cnt_t'(1);
      end else if (dec_i && (32'(dec_addr_i) == i) &&
                   !(inc_i && (32'(inc_addr_i) == i))) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - pend_cnt_t'(1);
        end else begin
          underflow_o = 1'b1;
        end
      end
      mask_d[i] = |cnt_d[i];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q  <= '{default: '0};
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  assign mask_o = mask_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// In-order RAW / write-overflow hazard scoreboard for the scalar and vector
// register files; stalls decode until outstanding writes have committed.
module regfile_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int unsigned SCALAR_REGNUM   = 16,
  parameter int unsigned VECTOR_REGNUM   = 16,
  parameter int unsigned ADDRESS_WIDTH   = AddrWidth,
  parameter int unsigned MAX_PENDING     = MaxPending,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       issueValid,
  input  logic                       issueIsVector,
  input  logic                       issueUsesReg1,
  input  logic                       issueUsesReg2,
  input  logic                       issueWritesDest,
  input  logic [ADDRESS_WIDTH-1:0]   reg1Address,
  input  logic [ADDRESS_WIDTH-1:0]   reg2Address,
  input  logic [ADDRESS_WIDTH-1:0]   regDestinationAddress,
  output logic                       issueReady,
  output logic                       stall,
  input  logic                       wbScalarValid,
  input  logic [ADDRESS_WIDTH-1:0]   wbScalarAddress,
  input  logic                       wbVectorValid,
  input  logic [ADDRESS_WIDTH-1:0]   wbVectorAddress,
  output logic [SCALAR_REGNUM-1:0]   pendingScalarMask,
  output logic [VECTOR_REGNUM-1:0]   pendingVectorMask,
  output logic [STALL_CNT_WIDTH-1:0] stallCount,
  output logic                       underflowError
);

  issue_req_t req;
  pend_cnt_t  s_rd1, s_rd2, s_rdd;
  pend_cnt_t  v_rd1, v_rd2, v_rdd;
  pend_cnt_t  eff1, eff2, effd;
  logic       raw_hazard, ovf_hazard, accept_write;
  logic       s_underflow, v_underflow;

  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
  logic                       underflow_q;

  assign req = '{
    valid:       issueValid,
    is_vector:   issueIsVector,
    uses_reg1:   issueUsesReg1,
    uses_reg2:   issueUsesReg2,
    writes_dest: issueWritesDest,
    reg1_addr:   reg1Address,
    reg2_addr:   reg2Address,
    dest_addr:   regDestinationAddress
  };

  always_comb begin
    eff1         = req.is_vector ? v_rd1 : s_rd1;
    eff2         = req.is_vector ? v_rd2 : s_rd2;
    effd         = req.is_vector ? v_rdd : s_rdd;
    raw_hazard   = (req.uses_reg1 && (eff1 != '0)) || (req.uses_reg2 && (eff2 != '0));
    ovf_hazard   = req.writes_dest && (effd == pend_cnt_t'(MAX_PENDING));
    issueReady   = !reset && !raw_hazard && !ovf_hazard;
    stall        = req.valid && !issueReady && !reset;
    accept_write = req.valid && issueReady && req.writes_dest;
  end

  pending_table #(
    .RegNum (SCALAR_REGNUM),
    .AddrW  (ADDRESS_WIDTH)
  ) u_scalar_table (
    .clock_i     (clock),
    .reset_i     (reset),
    .inc_i       (accept_write && !req.is_vector),
    .inc_addr_i  (req.dest_addr),
    .dec_i       (wbScalarValid),
    .dec_addr_i  (wbScalarAddress),
    .rd1_addr_i  (req.reg1_addr),
    .rd2_addr_i  (req.reg2_addr),
    .rdd_addr_i  (req.dest_addr),
    .rd1_cnt_o   (s_rd1),
    .rd2_cnt_o   (s_rd2),
    .rdd_cnt_o   (s_rdd),
    .mask_o      (pendingScalarMask),
    .underflow_o (s_underflow)
  );

  pending_table #(
    .RegNum (VECTOR_REGNUM),
    .AddrW  (ADDRESS_WIDTH)
  ) u_vector_table (
    .clock_i     (clock),
    .reset_i     (reset),
    .inc_i       (accept_write && req.is_vector),
    .inc_addr_i  (req.dest_addr),
    .dec_i       (wbVectorValid),
    .dec_addr_i  (wbVectorAddress),
    .rd1_addr_i  (req.reg1_addr),
    .rd2_addr_i  (req.reg2_addr),
    .rdd_addr_i  (req.dest_addr),
    .rd1_cnt_o   (v_rd1),
    .rd2_cnt_o   (v_rd2),
    .rdd_cnt_o   (v_rdd),
    .mask_o      (pendingVectorMask),
    .underflow_o (v_underflow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (s_underflow || v_underflow) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign stallCount     = stall_cnt_q;
  assign underflowError = underflow_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard plus hand-written
// sequences for writeback underflow and asynchronous mid-cycle reset.
module tb_regfile_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issueValid, issueIsVector, issueUsesReg1, issueUsesReg2, issueWritesDest;
  logic [3:0]  reg1Address, reg2Address, regDestinationAddress;
  logic        issueReady, stall;
  logic        wbScalarValid, wbVectorValid;
  logic [3:0]  wbScalarAddress, wbVectorAddress;
  logic [15:0] pendingScalarMask, pendingVectorMask, stallCount;
  logic        underflowError;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_scoreboard dut (
    .clock                 (clock),
    .reset                 (reset),
    .issueValid            (issueValid),
    .issueIsVector         (issueIsVector),
    .issueUsesReg1         (issueUsesReg1),
    .issueUsesReg2         (issueUsesReg2),
    .issueWritesDest       (issueWritesDest),
    .reg1Address           (reg1Address),
    .reg2Address           (reg2Address),
    .regDestinationAddress (regDestinationAddress),
    .issueReady            (issueReady),
    .stall                 (stall),
    .wbScalarValid         (wbScalarValid),
    .wbScalarAddress       (wbScalarAddress),
    .wbVectorValid         (wbVectorValid),
    .wbVectorAddress       (wbVectorAddress),
    .pendingScalarMask     (pendingScalarMask),
    .pendingVectorMask     (pendingVectorMask),
    .stallCount            (stallCount),
    .underflowError        (underflowError)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid, vec, u1, u2, wd;
    logic [3:0]  a1, a2, ad;
    logic        wbs;
    logic [3:0]  wbsa;
    logic        wbv;
    logic [3:0]  wbva;
    logic        rdy, stl;
    logic [15:0] smask, vmask, scnt;
    logic        uf;
  } vec_t;

  function automatic vec_t mk(int valid, int vec, int u1, int u2, int wd,
                              int a1, int a2, int ad, int wbs, int wbsa, int wbv, int wbva,
                              int rdy, int stl, int smask, int vmask, int scnt, int uf);
    vec_t v;
    v.valid = 1'(valid); v.vec = 1'(vec); v.u1 = 1'(u1); v.u2 = 1'(u2); v.wd = 1'(wd);
    v.a1 = 4'(a1); v.a2 = 4'(a2); v.ad = 4'(ad);
    v.wbs = 1'(wbs); v.wbsa = 4'(wbsa); v.wbv = 1'(wbv); v.wbva = 4'(wbva);
    v.rdy = 1'(rdy); v.stl = 1'(stl);
    v.smask = 16'(smask); v.vmask = 16'(vmask); v.scnt = 16'(scnt); v.uf = 1'(uf);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issueValid = v.valid; issueIsVector = v.vec; issueUsesReg1 = v.u1;
    issueUsesReg2 = v.u2; issueWritesDest = v.wd;
    reg1Address = v.a1; reg2Address = v.a2; regDestinationAddress = v.ad;
    wbScalarValid = v.wbs; wbScalarAddress = v.wbsa;
    wbVectorValid = v.wbv; wbVectorAddress = v.wbva;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " issueReady"}, 32'(issueReady), 32'(v.rdy));
    chk({tag, " stall"}, 32'(stall), 32'(v.stl));
    chk({tag, " scalarMask"}, 32'(pendingScalarMask), 32'(v.smask));
    chk({tag, " vectorMask"}, 32'(pendingVectorMask), 32'(v.vmask));
    chk({tag, " stallCount"}, 32'(stallCount), 32'(v.scnt));
    chk({tag, " underflow"}, 32'(underflowError), 32'(v.uf));
  endtask

  vec_t vecs[$];
  vec_t idle;

  initial begin
    // Reset state, with a valid request present to show stall is held low.
    reset = 1'b1;
    drive(mk(1,0,1,0,1, 3,0,3, 0,0,0,0, 0,0,0,0,0,0));
    #2;
    chk_all("reset", mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0));
    idle = mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0);
    drive(idle);

    // scalar r3: write, blocked reads, same-cycle writeback bypass
    vecs.push_back(mk(1,0,0,0,1, 0,0,3, 0,0,0,0, 1,0,'h0000,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 3,0,0, 0,0,0,0, 0,1,'h0008,0,0,0));
    vecs.push_back(mk(1,0,1,0,0, 3,0,0, 0,0,0,0, 0,1,'h0008,0,1,0));
    vecs.push_back(mk(1,0,1,0,0, 3,0,0, 1,3,0,0, 1,0,'h0008,0,2,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 1,0,'h0000,0,2,0));
    // scalar r5: fill to MAX_PENDING, overflow stall, bypass acceptance, drain
    vecs.push_back(mk(1,0,0,0,1, 0,0,5, 0,0,0,0, 1,0,'h0000,0,2,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,5, 0,0,0,0, 1,0,'h0020,0,2,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,5, 0,0,0,0, 1,0,'h0020,0,2,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,5, 0,0,0,0, 0,1,'h0020,0,2,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,5, 1,5,0,0, 1,0,'h0020,0,3,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,5, 0,0,0,0, 0,1,'h0020,0,3,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,5,0,0, 1,0,'h0020,0,4,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,5,0,0, 1,0,'h0020,0,4,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,5,0,0, 1,0,'h0020,0,4,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 1,0,'h0000,0,4,0));
    // v2 pending: scalar r2 read is free, vector v2 read stalls
    vecs.push_back(mk(1,1,0,0,1, 0,0,2, 0,0,0,0, 1,0,0,'h0000,4,0));
    vecs.push_back(mk(1,0,1,0,0, 2,0,0, 0,0,0,0, 1,0,0,'h0004,4,0));
    vecs.push_back(mk(1,1,0,1,0, 0,2,0, 0,0,0,0, 0,1,0,'h0004,4,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,1,2, 1,0,0,'h0004,5,0));
    // r7 at count 1: issue + writeback same cycle keeps count at 1
    vecs.push_back(mk(1,0,0,0,1, 0,0,7, 0,0,0,0, 1,0,'h0000,0,5,0));
    vecs.push_back(mk(1,0,0,0,1, 0,0,7, 1,7,0,0, 1,0,'h0080,0,5,0));
    vecs.push_back(mk(1,0,1,0,0, 7,0,0, 0,0,0,0, 0,1,'h0080,0,5,0));
    vecs.push_back(mk(0,0,1,0,0, 7,0,0, 0,0,0,0, 0,0,'h0080,0,6,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 1,7,0,0, 1,0,'h0080,0,6,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 1,0,'h0000,0,6,0));

    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i]);
      @(negedge clock);
    end

    // Vector writeback to idle v9: sticky underflow, counter stays 0.
    drive(mk(0,0,0,0,0, 0,0,0, 0,0,1,9, 0,0,0,0,0,0));
    #2;
    chk("uf before edge", 32'(underflowError), 32'd0);
    @(negedge clock);
    drive(mk(1,1,1,0,0, 9,0,0, 0,0,0,0, 0,0,0,0,0,0));
    #2;
    chk("uf set", 32'(underflowError), 32'd1);
    chk("uf v9 read ready", 32'(issueReady), 32'd1);
    chk("uf vmask", 32'(pendingVectorMask), 32'd0);
    drive(idle);
    repeat (3) @(negedge clock);
    #2;
    chk("uf sticky", 32'(underflowError), 32'd1);

    // r1 and v4 pending, then reset asserted between edges.
    @(negedge clock);
    drive(mk(1,0,0,0,1, 0,0,1, 0,0,0,0, 0,0,0,0,0,0));
    @(negedge clock);
    drive(mk(1,1,0,0,1, 0,0,4, 0,0,0,0, 0,0,0,0,0,0));
    @(negedge clock);
    drive(mk(1,0,1,0,0, 1,0,0, 0,0,0,0, 0,0,0,0,0,0));
    #2;
    chk("pre-rst smask", 32'(pendingScalarMask), 32'h0002);
    chk("pre-rst vmask", 32'(pendingVectorMask), 32'h0010);
    chk("pre-rst stall", 32'(stall), 32'd1);
    chk("pre-rst stallCount", 32'(stallCount), 32'd6);
    #1;
    reset = 1'b1;
    #1;
    chk("async rst smask", 32'(pendingScalarMask), 32'h0);
    chk("async rst vmask", 32'(pendingVectorMask), 32'h0);
    chk("async rst stallCount", 32'(stallCount), 32'd0);
    chk("async rst underflow", 32'(underflowError), 32'd0);
    chk("async rst ready", 32'(issueReady), 32'd0);
    chk("async rst stall", 32'(stall), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #2;
    chk("post-rst r1 ready", 32'(issueReady), 32'd1);
    chk("post-rst r1 stall", 32'(stall), 32'd0);
    @(negedge clock);
    drive(idle);
    #2;
    chk("post-rst smask", 32'(pendingScalarMask), 32'h0);
    chk("post-rst stallCount", 32'(stallCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- In-order hazard scoreboard between the decode stage and the scalar/vector register files.
- Tracks outstanding writes per register: one counter table for the scalar file, one for the vector file.
- Stalls issue on read-after-write and write-overflow hazards.
- Retires entries when writeback commits, so decode never reads stale operands.

Parameters:
- SCALAR_REGNUM, 16, number of scalar registers tracked.
- VECTOR_REGNUM, 16, number of vector registers tracked.
- ADDRESS_WIDTH, 4, register address width.
- MAX_PENDING, 3, maximum outstanding writes per register; counter width is $clog2(MAX_PENDING+1).
- STALL_CNT_WIDTH, 16, width of the stall performance counter.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- issueValid  in  1  decode presents an instruction.
- issueIsVector  in  1  operands and destination are in the vector file (0 = scalar).
- issueUsesReg1  in  1  instruction reads reg1Address.
- issueUsesReg2  in  1  instruction reads reg2Address.
- issueWritesDest  in  1  instruction writes regDestinationAddress.
- reg1Address  in  ADDRESS_WIDTH  source 1.
- reg2Address  in  ADDRESS_WIDTH  source 2.
- regDestinationAddress  in  ADDRESS_WIDTH  destination.
- issueReady  out  1  no hazard; the instruction is accepted when issueValid && issueReady.
- stall  out  1  issueValid && !issueReady.
- wbScalarValid  in  1  scalar writeback commits this cycle.
- wbScalarAddress  in  ADDRESS_WIDTH  scalar writeback register.
- wbVectorValid  in  1  vector writeback commits this cycle.
- wbVectorAddress  in  ADDRESS_WIDTH  vector writeback register.
- pendingScalarMask  out  SCALAR_REGNUM  bit i = scalar counter i nonzero.
- pendingVectorMask  out  VECTOR_REGNUM  bit i = vector counter i nonzero.
- stallCount  out  STALL_CNT_WIDTH  saturating count of stall cycles.
- underflowError  out  1  sticky flag: writeback to a register with counter 0.

Behaviour:
- Reset (async, active-high): all counters 0, masks 0, stallCount 0, underflowError 0.
  - While reset is high, issueReady = 0 and stall = 0.
  - Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
- Table selection: issueIsVector selects which counter table the hazard check uses and which table the issue increments.
- Effective count of a register: effective(r) = count(r) − (same-table writeback to r this cycle ? 1 : 0).
  - The register files write on the falling edge, so same-cycle writeback data is readable. Same-cycle writeback therefore bypasses the hazard.
- RAW hazard: (issueUsesReg1 && effective(reg1Address) != 0) or (issueUsesReg2 && effective(reg2Address) != 0).
- Overflow hazard: issueWritesDest && effective(regDestinationAddress) == MAX_PENDING.
- Readiness: issueReady = !reset && !RAW && !overflow. It is combinational from the inputs and current counters.
  - issueReady does not depend on issueValid.
- Counter update on the rising edge, per register:
  - +1 if an issue is accepted that writes it in that table.
  - −1 if a writeback to it is valid in that table.
  - Both in the same cycle: net unchanged.
  - Scalar and vector writebacks in the same cycle update their own tables independently.
- Underflow: a writeback to a register with count 0 (and no same-cycle accepted issue to it) leaves count at 0 and sets underflowError.
  - underflowError is cleared only by reset.
- Counters never exceed MAX_PENDING; the overflow hazard guarantees this.
- stallCount: increments on every cycle where stall = 1 and holds at the all-ones value.
- Masks: registered view, reduction-OR of each counter. They update the cycle after a counter change.
- Latency: issue to pending-mask visible is 1 cycle. Writeback clears the hazard in the same cycle via the bypass.
- Address bounds: addresses ≥ REGNUM are ignored for the update and treated as hazard-free.

Decomposition:
- Shared package scoreboard_pkg holds:
  - the counter width constant;
  - typedef pend_cnt_t;
  - typedef struct issue_req_t (valid, isVector, usesReg1, usesReg2, writesDest, three addresses).
- One natural sub-module, pending_table, instantiated twice (scalar and vector):
  - REGNUM counters;
  - inc/dec ports;
  - two read ports returning effective count for hazard checks, plus one destination read port;
  - mask output;
  - underflow pulse.

Test Plan:
- Reset then issue scalar write to r3 → pendingScalarMask = 0x0008 next cycle. Next instruction reading scalar r3 → issueReady = 0, stall = 1, stallCount increments each cycle. wbScalarValid to r3 → issueReady = 1 in that same cycle, mask = 0 next cycle.
- Three accepted scalar writes to r5 with no writeback → a fourth write to r5 stalls. One writeback to r5 in the same cycle → fourth issue accepted, count stays 3.
- Vector write pending on v2; scalar instruction reads r2 → no stall (tables independent). Vector read of v2 → stall.
- Same cycle: accepted issue writing scalar r7 plus wbScalar to r7 while count = 1 → count stays 1, mask bit 7 stays set.
- wbVectorValid to v9 with count 0 → underflowError = 1 and stays 1 until reset; count stays 0.
- Reset asserted between clock edges with r1 and v4 pending → masks, stallCount and underflowError clear immediately. After reset release, a read of r1 issues without stall.
